// File: rtl/watchdog_timer.sv
// rtl/watchdog_timer.sv - memory-mapped two-stage watchdog (warn, then reset request)
//
// Purpose: firmware must write KICK_KEY to the KICK register periodically.
// A missed period raises warn; a second missed period, or a kick with the
// wrong key, drives reset_request high for PULSE_CYCLES clocks.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   sel            block selected, held until ready
//   wstrb[3:0]     byte write strobes, 0 = read
//   addr[1:0]      word index: 0 CTRL, 1 LOAD, 2 COUNT, 3 KICK
//   data_i[31:0]   write data
//   ready          one-cycle access-complete pulse
//   data_o[31:0]   read data, zero unless ready=1
//   warn           first timeout has occurred (level)
//   reset_request  bite pulse to the reset controller
module watchdog_timer #(
  parameter int          PRESCALE_BITS = 8,
  parameter int          PULSE_CYCLES  = 16,
  parameter logic [31:0] KICK_KEY      = 32'h5A5AA5A5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  wstrb,
  input  logic [1:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        warn,
  output logic        reset_request
);

  typedef enum logic [1:0] {IDLE, RUN, WARN, BITE} state_t;

  state_t                   state, state_n;
  logic                     served;
  logic                     en, lock;
  logic [23:0]              load, count;
  logic [PRESCALE_BITS-1:0] psc;
  logic [7:0]               pulse_cnt;

  logic        wr, wr_ctrl, wr_load, kick, kick_ok;
  logic        tick, counting;
  logic        reload, set_warn, clr_warn, clr_en;
  logic [31:0] rdata;

  // Writes take effect at the end of the ready cycle.
  assign wr       = ready & sel & (wstrb != 4'b0000);
  assign wr_ctrl  = wr & (addr == 2'd0) & wstrb[0] & ~lock & (state != BITE);
  assign wr_load  = wr & (addr == 2'd1) & ~lock;
  assign kick     = wr & (addr == 2'd3) & (wstrb == 4'hF);
  assign kick_ok  = kick & (data_i == KICK_KEY);
  assign tick     = &psc;
  assign counting = (state == RUN) || (state == WARN);

  // Priority inside RUN/WARN: disable, then kick, then expiry.
  always_comb begin
    state_n  = state;
    reload   = 1'b0;
    set_warn = 1'b0;
    clr_warn = 1'b0;
    clr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ctrl && data_i[0]) begin
          state_n  = RUN;
          reload   = 1'b1;
          clr_warn = 1'b1;
        end
      end
      RUN, WARN: begin
        if (wr_ctrl && !data_i[0]) begin
          state_n  = IDLE;
          clr_warn = 1'b1;
        end else if (kick_ok) begin
          state_n  = RUN;
          reload   = 1'b1;
          clr_warn = 1'b1;
        end else if (kick) begin
          state_n = BITE;
        end else if (tick && (count == 24'd0)) begin
          if (state == RUN) begin
            state_n  = WARN;
            set_warn = 1'b1;
            reload   = 1'b1;
          end else begin
            state_n = BITE;
          end
        end
      end
      BITE: begin
        if (pulse_cnt == 8'(PULSE_CYCLES - 1)) begin
          state_n  = IDLE;
          clr_warn = 1'b1;
          clr_en   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Counter datapath. The prescaler only advances while the machine stays
  // in a counting state, so it freezes as soon as we leave RUN/WARN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= 24'hFFFFFF;
      psc       <= '0;
      pulse_cnt <= 8'd0;
      warn      <= 1'b0;
      en        <= 1'b0;
      lock      <= 1'b0;
      load      <= 24'hFFFFFF;
    end else begin
      if (reload) begin
        count <= load;
        psc   <= '0;
      end else if (counting && (state_n == RUN || state_n == WARN)) begin
        psc <= psc + 1'b1;
        if (tick && (count != 24'd0)) begin
          count <= count - 24'd1;
        end
      end

      if (state == BITE) begin
        pulse_cnt <= pulse_cnt + 8'd1;
      end else begin
        pulse_cnt <= 8'd0;
      end

      if (clr_warn) begin
        warn <= 1'b0;
      end else if (set_warn) begin
        warn <= 1'b1;
      end

      if (clr_en) begin
        en <= 1'b0;
      end else if (wr_ctrl) begin
        en <= data_i[0];
      end

      if (wr_ctrl && data_i[1]) begin
        lock <= 1'b1;
      end

      for (int i = 0; i < 3; i++) begin
        if (wr_load && wstrb[i]) begin
          load[8*i +: 8] <= data_i[8*i +: 8];
        end
      end
    end
  end

  // Registered so the reset path sees a glitch-free level; the async reset
  // still drops it immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reset_request <= 1'b0;
    end else begin
      reset_request <= (state_n == BITE);
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0: rdata = {30'd0, lock, en};
      2'd1: rdata = {8'd0, load};
      2'd2: rdata = {8'd0, count};
      2'd3: rdata = {30'd0, reset_request, warn};
      default: rdata = 32'd0;
    endcase
  end

  // One ready pulse per sel assertion; served blocks a second access until
  // sel drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      served <= 1'b0;
      ready  <= 1'b0;
      data_o <= 32'd0;
    end else if (!sel) begin
      served <= 1'b0;
      ready  <= 1'b0;
      data_o <= 32'd0;
    end else if (!served) begin
      served <= 1'b1;
      ready  <= 1'b1;
      data_o <= (wstrb == 4'b0000) ? rdata : 32'd0;
    end else begin
      ready  <= 1'b0;
      data_o <= 32'd0;
    end
  end

endmodule

// File: tb/tb_watchdog_timer.sv
// tb/tb_watchdog_timer.sv - scoreboard bench for watchdog_timer
module tb_watchdog_timer;

  localparam logic [31:0] KEY = 32'h5A5AA5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [3:0]  wstrb;
  logic [1:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;
  logic        warn;
  logic        reset_request;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic        rr_at_ready;

  watchdog_timer #(
    .PRESCALE_BITS(2),
    .PULSE_CYCLES (16),
    .KICK_KEY     (KEY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sel          (sel),
    .wstrb        (wstrb),
    .addr         (addr),
    .data_i       (data_i),
    .ready        (ready),
    .data_o       (data_o),
    .warn         (warn),
    .reset_request(reset_request)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse pops one expected read value.
  always @(negedge clk) begin
    if (ready) begin
      if (exp_q.size() == 0) check("unexpected_ready", 32'd1, 32'd0);
      else check("data_o", data_o, exp_q.pop_front());
    end else begin
      check("data_o_idle", data_o, 32'd0);
    end
  end

  task automatic bus(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                     input logic [31:0] exp);
    int n;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    sel = 1'b1; addr = a; wstrb = s; data_i = d;
    n = 0;
    while (!ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
    rr_at_ready = reset_request;
    @(posedge clk); #1;
    sel = 1'b0; wstrb = 4'h0; data_i = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    bus(a, 4'h0, 32'd0, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
    bus(a, s, d, 32'd0);
  endtask

  // Waits until the chosen output reaches level; n = cycles waited or -1.
  task automatic wait_sig(input bit use_rr, input bit level, output int n);
    n = 0;
    while (((use_rr ? reset_request : warn) != level) && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    if ((use_rr ? reset_request : warn) != level) n = -1;
  endtask

  initial begin
    int k, n;
    bit seen;
    int pulses, first_at;

    reset = 1'b1; sel = 1'b0; wstrb = 4'h0; addr = 2'd0; data_i = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_warn", {31'd0, warn}, 32'd0);
    check("rst_rr", {31'd0, reset_request}, 32'd0);
    rd(2'd0, 32'd0);
    rd(2'd1, 32'h00FFFFFF);
    rd(2'd2, 32'h00FFFFFF);
    rd(2'd3, 32'd0);

    // Full timeout sequence: LOAD=3, tick every 4 clk
    wr(2'd1, 4'hF, 32'hAB000003);
    rd(2'd1, 32'd3);
    wr(2'd0, 4'h1, 32'd1);
    k = cyc;
    rd(2'd2, 32'd3);
    rd(2'd2, 32'd2);
    wait_sig(1'b0, 1'b1, n);
    check("warn_rise_cycle", cyc - k, 32'd16);
    wait_sig(1'b1, 1'b1, n);
    check("rr_rise_cycle", cyc - k, 32'd32);
    check("warn_in_bite", {31'd0, warn}, 32'd1);
    wait_sig(1'b1, 1'b0, n);
    check("rr_fall_cycle", cyc - k, 32'd48);
    check("warn_after_bite", {31'd0, warn}, 32'd0);
    rd(2'd0, 32'd0);

    // Periodic kicks keep it alive
    wr(2'd0, 4'h1, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr(2'd3, 4'hF, KEY);
      rd(2'd2, 32'd3);
      repeat (4) begin
        @(posedge clk); #1;
        seen |= warn | reset_request;
      end
    end
    check("kick_no_timeout", {31'd0, seen}, 32'd0);

    // Enter WARN, partial-strobe kick ignored, wrong key bites
    wait_sig(1'b0, 1'b1, n);
    check("warn_after_kicks_stop", (n >= 0) ? 32'd1 : 32'd0, 32'd1);
    wr(2'd3, 4'h1, KEY);
    check("partial_kick_no_bite", {31'd0, reset_request}, 32'd0);
    check("partial_kick_warn_kept", {31'd0, warn}, 32'd1);
    wr(2'd3, 4'hF, 32'h12345678);
    check("wrongkey_rr_at_ready", {31'd0, rr_at_ready}, 32'd0);
    check("wrongkey_rr_after", {31'd0, reset_request}, 32'd1);

    // Asynchronous reset in the middle of BITE
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_rr", {31'd0, reset_request}, 32'd0);
    check("async_rst_warn", {31'd0, warn}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    rd(2'd0, 32'd0);
    rd(2'd2, 32'h00FFFFFF);
    rd(2'd3, 32'd0);

    // LOAD=0 expires on the first tick; disable clears warn
    wr(2'd1, 4'hF, 32'd0);
    wr(2'd0, 4'h1, 32'd1);
    k = cyc;
    wait_sig(1'b0, 1'b1, n);
    check("load0_warn_cycle", cyc - k, 32'd4);
    wr(2'd0, 4'h1, 32'd0);
    check("disable_clears_warn", {31'd0, warn}, 32'd0);
    rd(2'd3, 32'd0);

    // LOCK
    wr(2'd1, 4'hF, 32'h00FFFFFF);
    wr(2'd0, 4'h1, 32'd3);
    rd(2'd0, 32'd3);
    wr(2'd0, 4'h1, 32'd0);
    wr(2'd1, 4'hF, 32'd5);
    rd(2'd0, 32'd3);
    rd(2'd1, 32'h00FFFFFF);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    rd(2'd0, 32'd0);

    // sel held 4 cycles: exactly one ready, one cycle after sel
    exp_q.push_back(32'h00FFFFFF);
    @(posedge clk); #1;
    sel = 1'b1; addr = 2'd2; wstrb = 4'h0;
    pulses = 0; first_at = -1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
    sel = 1'b0;
    check("hold_sel_pulses", pulses, 32'd1);
    check("hold_sel_latency", first_at, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
